// File: rtl/lab5rr_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lab5rr_arb_if                                          |
// | Description : Request/data/grant bundle shared by the four           |
// |               requesters and the round-robin arbiter.                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface lab5rr_arb_if;
  logic [3:0] req;
  logic       d0;
  logic       d1;
  logic       d2;
  logic       d3;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       valid;
  logic       y;

  // Requester side: raises requests and supplies data, observes the grant.
  modport master (
    output req, d0, d1, d2, d3,
    input  gnt, s, valid, y
  );

  // Arbiter side.
  modport slave (
    input  req, d0, d1, d2, d3,
    output gnt, s, valid, y
  );
endinterface
`default_nettype wire

// File: rtl/lab5rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lab5rr_arb                                             |
// | Description : Round-robin arbiter sharing one 1-bit 4:1 mux between  |
// |               four requesters, with a bounded hold per grant and a   |
// |               registered selected data bit.                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lab5rr_arb #(
  parameter int MAXHOLD = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  lab5rr_arb_if.slave      bus
);

  localparam logic [0:0] c_idle      = 1'b0;
  localparam logic [0:0] c_busy      = 1'b1;
  localparam logic [2:0] c_hold_last = 3'(MAXHOLD - 1);

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [2:0] r_hold;

  logic [3:0] w_owner_oh;
  logic       w_own_req;
  logic       w_others;
  logic       w_at_limit;
  logic       w_release;
  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_scan;
  logic       w_dsel;

  // While busy the registered select names the current owner.
  always_comb begin
    w_owner_oh = 4'b0001 << bus.s;
    w_own_req  = bus.req[bus.s];
    w_others   = |(bus.req & ~w_owner_oh);
    w_at_limit = (r_hold == c_hold_last);
    w_release  = !w_own_req || (w_at_limit && w_others);
  end

  // Rotating priority scan from r_ptr; the owner is excluded while busy.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_scan  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_scan = r_ptr + 2'(k);
      if (bus.req[w_scan] && !((r_state == c_busy) && (w_scan == bus.s))) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
    end
  end

  // Data bit of whichever requester the registered select points at.
  always_comb begin
    case (bus.s)
      2'd0:    w_dsel = bus.d0;
      2'd1:    w_dsel = bus.d1;
      2'd2:    w_dsel = bus.d2;
      default: w_dsel = bus.d3;
    endcase
  end

  // Grant sequencing: idle pick, hand-off on drop/timeout, hold counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_idle;
      r_ptr     <= 2'd0;
      r_hold    <= 3'd0;
      bus.gnt   <= 4'b0000;
      bus.s     <= 2'd0;
      bus.valid <= 1'b0;
    end else if (r_state == c_idle) begin
      if (w_found) begin
        r_state   <= c_busy;
        r_ptr     <= w_pick + 2'd1;
        r_hold    <= 3'd0;
        bus.gnt   <= 4'b0001 << w_pick;
        bus.s     <= w_pick;
        bus.valid <= 1'b1;
      end
    end else begin
      if (w_release && w_found) begin
        // Direct hand-off to the next requester, no idle bubble.
        r_ptr   <= w_pick + 2'd1;
        r_hold  <= 3'd0;
        bus.gnt <= 4'b0001 << w_pick;
        bus.s   <= w_pick;
      end else if (!w_own_req) begin
        // Owner dropped and nobody else wants it; select is left as is.
        r_state   <= c_idle;
        r_hold    <= 3'd0;
        bus.gnt   <= 4'b0000;
        bus.valid <= 1'b0;
      end else if (w_at_limit) begin
        // Sole requester at the limit keeps the grant; the count wraps.
        r_hold <= 3'd0;
      end else begin
        r_hold <= r_hold + 3'd1;
      end
    end
  end

  // Output data register: owner's bit one cycle after the select settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y <= 1'b0;
    end else begin
      bus.y <= bus.valid ? w_dsel : 1'b0;
    end
  end

endmodule
`default_nettype wire
